mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Purpose : bundles the two requester handshakes (instruction fetch and data
//           load/store) and the single-port memory handshake that the
//           arbiter sits between.
// Signals : i_*    fetch requester   (req/addr in, done/rdata out)
//           d_*    data requester    (req/we/addr/wdata in, done/rdata out)
//           mem_*  memory side       (req/we/addr/wdata out, rdata/ready in)
//           err    timeout flag accompanying a done pulse
//           owner  0 = fetch owns memory, 1 = data owns memory
// Modports: slave  - the arbiter's view
//           master - the view of whoever drives requests and models memory
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              err;
    logic              owner;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_done, i_rdata, d_done, d_rdata, err, owner,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_done, i_rdata, d_done, d_rdata, err, owner,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Purpose : shares one memory port between an instruction-fetch requester and
//           a data (load/store) requester. One access at a time, IDLE ->
//           BUSY_I/BUSY_D -> DONE -> IDLE, with round-robin tie breaking and a
//           BUSY-cycle timeout that completes the access with err=1.
// Ports   : clk    rising-edge clock
//           reset  asynchronous active-high reset
//           bus    mem_arbiter_if.slave (requester and memory handshakes)
// Params  : ADDR_W, DATA_W widths; TIMEOUT = max BUSY cycles (1..255)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              lastOwner_q, lastOwner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] iRdata_q, iRdata_d;
    logic [DATA_W-1:0] dRdata_q, dRdata_d;

    logic              grantData;
    logic              memReq;
    logic              iDone;
    logic              dDone;

    // State and captured-access registers. Reset parks the arbiter in IDLE
    // with lastOwner=1 so the very first tie goes to instruction fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            lastOwner_q <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            iRdata_q    <= '0;
            dRdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            iRdata_q    <= iRdata_d;
            dRdata_q    <= dRdata_d;
        end
    end

    // Next-state and output logic. Requests are looked at only in IDLE; once
    // granted, the memory-side address/we/wdata come purely from registers so
    // requester activity during BUSY or DONE cannot disturb the access.
    // In BUSY, mem_ready wins over the timeout when both land on one edge.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        iRdata_d    = iRdata_q;
        dRdata_d    = dRdata_q;
        grantData   = 1'b0;
        memReq      = 1'b0;
        iDone       = 1'b0;
        dDone       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    grantData = (bus.i_req && bus.d_req) ? ~lastOwner_q : bus.d_req;
                    owner_d   = grantData;
                    addr_d    = grantData ? bus.d_addr  : bus.i_addr;
                    we_d      = grantData ? bus.d_we    : 1'b0;
                    wdata_d   = grantData ? bus.d_wdata : '0;
                    cnt_d     = '0;
                    state_d   = grantData ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                memReq = 1'b1;
                if (bus.mem_ready) begin
                    if (state_q == BUSY_I) begin
                        iRdata_d = bus.mem_rdata;
                    end else if (!we_q) begin
                        dRdata_d = bus.mem_rdata;
                    end
                    err_d       = 1'b0;
                    lastOwner_d = owner_q;
                    state_d     = DONE;
                end else if ((cnt_q + 8'd1) == TIMEOUT_C) begin
                    err_d       = 1'b1;
                    lastOwner_d = owner_q;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                iDone   = ~owner_q;
                dDone   = owner_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_req   = memReq;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_done    = iDone;
    assign bus.d_done    = dDone;
    assign bus.i_rdata   = iRdata_q;
    assign bus.d_rdata   = dRdata_q;
    assign bus.err       = err_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Purpose : self-checking bench for mem_arbiter. A table of directed accesses
//           runs first, then a reset-in-BUSY sequence, then randomized
//           accesses whose expectations come from a small arbitration model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic clk;
    logic reset;

    int testsRun    = 0;
    int testsFailed = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iReq;
        logic        dReq;
        logic        dWe;
        logic [15:0] iAddr;
        logic [15:0] dAddr;
        logic [15:0] dWdata;
        int          readyDelay;
        logic [15:0] memRdata;
        logic        expOwner;
        logic        expErr;
        logic [15:0] expI;
        logic [15:0] expD;
    } vec_t;

    vec_t vecs[9];

    // Compare one observed value with its required value and log a failure.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Drive the requester side for the next IDLE sample.
    task automatic applyStimulus(input logic iReq, input logic [15:0] iAddr,
                                 input logic dReq, input logic dWe,
                                 input logic [15:0] dAddr, input logic [15:0] dWdata);
        bus.i_req   = iReq;
        bus.i_addr  = iAddr;
        bus.d_req   = dReq;
        bus.d_we    = dWe;
        bus.d_addr  = dAddr;
        bus.d_wdata = dWdata;
    endtask

    // Run one access from an IDLE negedge to the IDLE negedge after DONE.
    // The memory answers after readyDelay BUSY cycles (never, if that is
    // TIMEOUT or more). Requester inputs are scrambled while BUSY to show
    // they are ignored, then restored before the arbiter samples again.
    task automatic runAccess(input string tag, input logic expOwner,
                             input logic [15:0] expAddr, input logic expWe,
                             input logic [15:0] expWdata, input int readyDelay,
                             input logic [15:0] rdataVal, input logic expErr,
                             input logic [15:0] expI, input logic [15:0] expD);
        logic        sIReq, sDReq, sDWe;
        logic [15:0] sIAddr, sDAddr, sDWdata;
        int          busyHigh;
        int          expBusy;
        bit          stable;
        sIReq = bus.i_req;  sIAddr = bus.i_addr;
        sDReq = bus.d_req;  sDWe   = bus.d_we;
        sDAddr = bus.d_addr; sDWdata = bus.d_wdata;
        busyHigh = 0;
        stable   = 1'b1;
        expBusy  = expErr ? TIMEOUT : readyDelay + 1;

        @(posedge clk);
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checkOutput({tag, " mem_req"},   32'(bus.mem_req),   32'd1);
                checkOutput({tag, " mem_addr"},  32'(bus.mem_addr),  32'(expAddr));
                checkOutput({tag, " mem_we"},    32'(bus.mem_we),    32'(expWe));
                checkOutput({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'(expWdata));
                checkOutput({tag, " owner"},     32'(bus.owner),     32'(expOwner));
            end
            if (bus.mem_req === 1'b1) busyHigh++;
            if (bus.mem_addr !== expAddr || bus.mem_we !== expWe ||
                bus.mem_wdata !== expWdata || bus.owner !== expOwner ||
                bus.i_done !== 1'b0 || bus.d_done !== 1'b0) stable = 1'b0;
            bus.i_addr  = 16'($urandom);
            bus.d_addr  = 16'($urandom);
            bus.d_wdata = 16'($urandom);
            bus.d_we    = 1'($urandom);
            if (k == readyDelay) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rdataVal;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 16'($urandom);
            end
            @(posedge clk);
            if (k == readyDelay) break;
        end

        @(negedge clk);
        checkOutput({tag, " busy cycles"}, 32'(busyHigh), 32'(expBusy));
        checkOutput({tag, " busy stable"}, 32'(stable), 32'd1);
        checkOutput({tag, " i_done"},  32'(bus.i_done),  32'(!expOwner));
        checkOutput({tag, " d_done"},  32'(bus.d_done),  32'(expOwner));
        checkOutput({tag, " err"},     32'(bus.err),     32'(expErr));
        checkOutput({tag, " mem_req done"}, 32'(bus.mem_req), 32'd0);
        checkOutput({tag, " i_rdata"}, 32'(bus.i_rdata), 32'(expI));
        checkOutput({tag, " d_rdata"}, 32'(bus.d_rdata), 32'(expD));
        // A stray mem_ready outside BUSY must not be captured.
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        applyStimulus(expOwner ? sIReq : 1'b0, sIAddr,
                      expOwner ? 1'b0 : sDReq, sDWe, sDAddr, sDWdata);

        @(posedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        checkOutput({tag, " done cleared"}, 32'(bus.i_done | bus.d_done), 32'd0);
        checkOutput({tag, " idle mem_req"}, 32'(bus.mem_req), 32'd0);
        checkOutput({tag, " idle i_rdata"}, 32'(bus.i_rdata), 32'(expI));
        checkOutput({tag, " idle d_rdata"}, 32'(bus.d_rdata), 32'(expD));
    endtask

    initial begin
        logic        pendI, pendD, pDWe, winner, modelLast, expErr, rDWe;
        logic [15:0] pIAddr, pDAddr, pDWdata, mI, mD, rd, rIAddr, rDAddr, rDWdata;
        int          delay, doneSeen;

        // Directed table; lastOwner starts at 1 so the first tie goes to fetch.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 16'h0100, 16'h0200, 16'hBEEF, 1,  16'h1111, 1'b0, 1'b0, 16'h1111, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0200, 16'hBEEF, 0,  16'h2222, 1'b1, 1'b0, 16'h1111, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 0,  16'hA5A5, 1'b0, 1'b0, 16'hA5A5, 16'h0000};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h0030, 16'h0020, 16'h1234, 2,  16'h3333, 1'b1, 1'b0, 16'hA5A5, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0000, 3,  16'h4444, 1'b0, 1'b0, 16'h4444, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0040, 16'h0000, 0,  16'h5A5A, 1'b1, 1'b0, 16'h4444, 16'h5A5A};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0050, 16'h0000, 20, 16'h6666, 1'b1, 1'b1, 16'h4444, 16'h5A5A};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0060, 16'h0000, 14, 16'hC3C3, 1'b1, 1'b0, 16'h4444, 16'hC3C3};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 16'h0070, 16'h0000, 16'h0000, 20, 16'h7777, 1'b0, 1'b1, 16'h4444, 16'hC3C3};

        reset = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset mem_req",   32'(bus.mem_req),   32'd0);
        checkOutput("reset mem_we",    32'(bus.mem_we),    32'd0);
        checkOutput("reset mem_addr",  32'(bus.mem_addr),  32'd0);
        checkOutput("reset mem_wdata", 32'(bus.mem_wdata), 32'd0);
        checkOutput("reset dones",     32'(bus.i_done | bus.d_done), 32'd0);
        checkOutput("reset err",       32'(bus.err),       32'd0);
        checkOutput("reset i_rdata",   32'(bus.i_rdata),   32'd0);
        checkOutput("reset d_rdata",   32'(bus.d_rdata),   32'd0);
        checkOutput("reset owner",     32'(bus.owner),     32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].iReq, vecs[v].iAddr, vecs[v].dReq, vecs[v].dWe,
                          vecs[v].dAddr, vecs[v].dWdata);
            runAccess($sformatf("vec%0d", v), vecs[v].expOwner,
                      vecs[v].expOwner ? vecs[v].dAddr : vecs[v].iAddr,
                      vecs[v].expOwner ? vecs[v].dWe : 1'b0,
                      vecs[v].expOwner ? vecs[v].dWdata : 16'h0000,
                      vecs[v].readyDelay, vecs[v].memRdata, vecs[v].expErr,
                      vecs[v].expI, vecs[v].expD);
        end

        // Reset in the middle of a data load: mem_req falls with no clock
        // edge, and a late mem_ready after release produces no done pulse.
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0080, 16'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstbusy mem_req before", 32'(bus.mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rstbusy mem_req async", 32'(bus.mem_req),  32'd0);
        checkOutput("rstbusy mem_addr",      32'(bus.mem_addr), 32'd0);
        checkOutput("rstbusy i_rdata",       32'(bus.i_rdata),  32'd0);
        checkOutput("rstbusy d_rdata",       32'(bus.d_rdata),  32'd0);
        bus.d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hBAD0;
        doneSeen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.i_done === 1'b1 || bus.d_done === 1'b1 || bus.mem_req === 1'b1) doneSeen++;
        end
        bus.mem_ready = 1'b0;
        checkOutput("rstbusy late ready activity", 32'(doneSeen), 32'd0);
        checkOutput("rstbusy d_rdata after", 32'(bus.d_rdata), 32'd0);

        // Randomized accesses against the arbitration model: whoever alone
        // is asking wins; on a tie the one not served last wins; read data
        // is kept unless a load/fetch completes without timing out.
        modelLast = 1'b1;
        mI = 16'h0;
        mD = 16'h0;
        pendI = 1'b0;
        pendD = 1'b0;
        pIAddr = 16'h0; pDAddr = 16'h0; pDWdata = 16'h0; pDWe = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (!pendI && $urandom_range(0, 1) == 1) begin
                pendI = 1'b1; pIAddr = 16'($urandom);
            end
            if (!pendD && $urandom_range(0, 1) == 1) begin
                pendD = 1'b1; pDAddr = 16'($urandom);
                pDWdata = 16'($urandom); pDWe = 1'($urandom);
            end
            if (!pendI && !pendD) begin
                pendI = 1'b1; pIAddr = 16'($urandom);
            end
            rIAddr = pIAddr; rDAddr = pDAddr; rDWdata = pDWdata; rDWe = pDWe;
            applyStimulus(pendI, rIAddr, pendD, rDWe, rDAddr, rDWdata);
            winner = (pendI && pendD) ? !modelLast : pendD;
            if ($urandom_range(0, 7) == 0) delay = int'($urandom_range(TIMEOUT - 1, TIMEOUT + 3));
            else                           delay = int'($urandom_range(0, 4));
            rd     = 16'($urandom);
            expErr = (delay >= TIMEOUT);
            if (!expErr) begin
                if (!winner)    mI = rd;
                else if (!rDWe) mD = rd;
            end
            runAccess($sformatf("rnd%0d", n), winner,
                      winner ? rDAddr : rIAddr, winner ? rDWe : 1'b0,
                      winner ? rDWdata : 16'h0000, delay, rd, expErr, mI, mD);
            modelLast = winner;
            if (winner) pendD = 1'b0;
            else        pendI = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
